fb_draw_sequencer: RTL
======================

Name: fb_draw_sequencer

Overview:
Parametrised frame-buffer draw engine that replaces ad-hoc "fill then wait for VGA origin" write logic. It accepts draw commands (fill rectangle, clear, swap), walks the clipped rectangle row-major, and emits one address/data write per pixel toward the SDRAM write-FIFO side. It supports 1..NUM_BUF pages. A swap only takes effect on the VGA frame-start pulse, so the front page never changes mid-scan.

Parameters:
FB_W, 256, frame-buffer width in pixels (≥1)
FB_H, 256, frame-buffer height in pixels (≥1)
PIX_W, 16, pixel word width (15-bit RGB plus 1 pad bit by default)
COORD_W, 10, command coordinate/size width
ADDR_W, 23, SDRAM word address width
BASE_ADDR, 0, address of page 0
BUF_STRIDE, 65536, address distance between pages (must be ≥ FB_W*FB_H)
NUM_BUF, 2, number of pages (1..4)

Ports:
iCLK  in  1  system clock (sdram_ctrl_clk domain)
iRST_N  in  1  synchronous active-low reset
cmd_valid  in  1  command offered
cmd_ready  out  1  high only in IDLE
cmd_op  in  2  0=FILL, 1=CLEAR, 2=SWAP, 3=reserved (treated as NOP)
cmd_x0, cmd_y0  in  COORD_W  rectangle origin
cmd_w, cmd_h  in  COORD_W  rectangle size
cmd_color  in  PIX_W  fill value
iFRAME_START  in  1  one-cycle pulse at VGA (0,0), already synchronised to iCLK
wr_valid  out  1  write beat valid
wr_ready  in  1  write sink accepts beat
wr_addr  out  ADDR_W  pixel word address in back page
wr_data  out  PIX_W  pixel value
oFRONT_SEL  out  $clog2(NUM_BUF)+1  page currently scanned out
oFRONT_BASE  out  ADDR_W  BASE_ADDR + oFRONT_SEL*BUF_STRIDE, for the read side
oBUSY  out  1  high whenever not IDLE

Behaviour:
- Reset (iRST_N=0 at a clock edge): state=IDLE; wr_valid=0; wr_addr=0; wr_data=0; oFRONT_SEL=0; back page=(NUM_BUF>1)?1:0; oBUSY=0; cmd_ready=1 on the first cycle after reset. Reset mid-FILL or mid-WAIT_SYNC aborts immediately; no further beats are issued.
- States: IDLE, SETUP, FILL, WAIT_SYNC.
- IDLE: a command is accepted when cmd_valid&&cmd_ready.
  - FILL/CLEAR go to SETUP. CLEAR is FILL with x0=0, y0=0, w=FB_W, h=FB_H.
  - SWAP goes to WAIT_SYNC.
  - NOP stays in IDLE.
- SETUP (1 cycle): clip the rectangle.
  - x_end=min(x0+w, FB_W); y_end=min(y0+h, FB_H). Sums are computed in COORD_W+1 bits, with no wrap.
  - Empty if w==0, h==0, x0≥FB_W or y0≥FB_H. Empty goes to IDLE with no beats; otherwise go to FILL.
  - Load row_base = back_base + y0*FB_W. The only multiply is here; a single-cycle multiply is acceptable.
- FILL: wr_addr = row_base + x and wr_data = color, presented with wr_valid=1.
  - The beat and the wr_addr/wr_data values are held stable while wr_valid && !wr_ready.
  - On handshake: x++. When x==x_end-1: x=x0, y++, row_base+=FB_W.
  - The last handshake (x==x_end-1, y==y_end-1) deasserts wr_valid next cycle and returns to IDLE.
  - Back-to-back beats are allowed at 1 beat/cycle with wr_ready held high.
  - Beat count is exactly (x_end-x0)*(y_end-y0).
- WAIT_SYNC: an iFRAME_START pulse in this state swaps pages (front←back, back←next page mod NUM_BUF) and returns to IDLE.
  - oFRONT_SEL/oFRONT_BASE update on the cycle after the pulse.
  - A pulse coincident with SWAP acceptance (the cycle still in IDLE) is ignored; the swap waits for the next pulse.
  - NUM_BUF==1: SWAP waits for the pulse but changes no page (acts as a vsync barrier).
- Page rotation for NUM_BUF>2: front=(front+1) mod NUM_BUF and back=(front+2) mod NUM_BUF, both computed from the old front.
- The front page is never written: back≠front is guaranteed for NUM_BUF>1.

Decomposition:
- Package fb_draw_pkg holds:
  - the cmd_op encoding enum (OP_FILL, OP_CLEAR, OP_SWAP, OP_NOP);
  - the state enum;
  - a function page_base(sel) returning BASE_ADDR+sel*BUF_STRIDE.
- One sub-module, fb_rect_walker, holds the x/y/row_base counters and the valid/ready output register. The top holds the command FSM, clipping and page select.

Test Plan:
- FILL x0=2,y0=3,w=3,h=2,color=16'h7C00, wr_ready=1, back page 1 → exactly 6 beats at addresses 65536+3*256+{2,3,4} then 65536+4*256+{2,3,4}, data 7C00; returns to IDLE; cmd_ready high on the cycle after the last beat.
- FILL x0=254,y0=255,w=10,h=10 → clipped to 2 beats: 65536+65534 and 65536+65535. FILL w=0 → zero beats; cmd_ready back after 2 cycles.
- Backpressure: wr_ready toggles 1,0,0,1 on a 4-pixel fill → wr_addr/wr_data stable while stalled; exactly 4 beats; no address skipped or duplicated.
- SWAP with iFRAME_START pulsed in the acceptance cycle, then again 10 cycles later → oFRONT_SEL 0→1 only after the second pulse; the next FILL writes page 0 (base 0).
- NUM_BUF=3: three SWAPs → oFRONT_SEL 1,2,0; the back page is never equal to the front page.
- Reset asserted mid-FILL → next cycle wr_valid=0, oBUSY=0, oFRONT_SEL=0; no further beats issued.

Source files
------------

// File: rtl/fb_draw_pkg.sv
// Shared command/state encodings and page addressing for the frame-buffer draw engine.
package fb_draw_pkg;

    typedef enum logic [1:0] {
        OP_FILL  = 2'd0,
        OP_CLEAR = 2'd1,
        OP_SWAP  = 2'd2,
        OP_NOP   = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_FILL,
        S_WAIT_SYNC
    } state_e;

    // Callers narrow the result to their address width.
    function automatic int unsigned page_base(input int unsigned sel,
                                              input int unsigned base,
                                              input int unsigned stride);
        return base + sel * stride;
    endfunction

endpackage

// File: rtl/fb_draw_sequencer_if.sv
// Command and pixel-write handshake bundle; master issues commands and sinks writes.
interface fb_draw_sequencer_if #(
    parameter int PIX_W   = 16,
    parameter int COORD_W = 10,
    parameter int ADDR_W  = 23
);
    logic               cmd_valid;
    logic               cmd_ready;
    logic [1:0]         cmd_op;
    logic [COORD_W-1:0] cmd_x0;
    logic [COORD_W-1:0] cmd_y0;
    logic [COORD_W-1:0] cmd_w;
    logic [COORD_W-1:0] cmd_h;
    logic [PIX_W-1:0]   cmd_color;
    logic               wr_valid;
    logic               wr_ready;
    logic [ADDR_W-1:0]  wr_addr;
    logic [PIX_W-1:0]   wr_data;

    modport master (
        output cmd_valid, cmd_op, cmd_x0, cmd_y0, cmd_w, cmd_h, cmd_color, wr_ready,
        input  cmd_ready, wr_valid, wr_addr, wr_data
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_x0, cmd_y0, cmd_w, cmd_h, cmd_color, wr_ready,
        output cmd_ready, wr_valid, wr_addr, wr_data
    );
endinterface

// File: rtl/fb_rect_walker.sv
// Row-major walk over a pre-clipped rectangle, one registered write beat per pixel.
module fb_rect_walker #(
    parameter int FB_W   = 256,
    parameter int ADDR_W = 23,
    parameter int PIX_W  = 16,
    parameter int CW     = 11
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [CW-1:0]     x0,
    input  logic [CW-1:0]     y0,
    input  logic [CW-1:0]     x_end,
    input  logic [CW-1:0]     y_end,
    input  logic [ADDR_W-1:0] row_base,
    input  logic [PIX_W-1:0]  color,
    input  logic              ready,
    output logic              valid,
    output logic [ADDR_W-1:0] addr,
    output logic [PIX_W-1:0]  data,
    output logic              last
);
    logic [CW-1:0]     x, y, x_first, x_stop, y_stop;
    logic [ADDR_W-1:0] base;
    logic              fire, row_end;

    assign fire    = valid && ready;
    assign row_end = (x == x_stop - CW'(1));
    assign last    = fire && row_end && (y == y_stop - CW'(1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid <= 1'b0;
            addr  <= '0;
            data  <= '0;
        end else if (start) begin
            valid <= 1'b1;
            addr  <= row_base + ADDR_W'(x0);
            data  <= color;
        end else if (fire) begin
            if (last)
                valid <= 1'b0;
            else if (row_end)
                addr <= base + ADDR_W'(FB_W) + ADDR_W'(x_first);
            else
                addr <= addr + ADDR_W'(1);
        end
    end

    // Counters need no reset: they are always loaded by start before use.
    always_ff @(posedge clk) begin
        if (start) begin
            x       <= x0;
            y       <= y0;
            x_first <= x0;
            x_stop  <= x_end;
            y_stop  <= y_end;
            base    <= row_base;
        end else if (fire && !last) begin
            if (row_end) begin
                x    <= x_first;
                y    <= y + CW'(1);
                base <= base + ADDR_W'(FB_W);
            end else begin
                x <= x + CW'(1);
            end
        end
    end
endmodule

// File: rtl/fb_draw_sequencer.sv
// Frame-buffer draw engine: command FSM, rectangle clipping and vsync-aligned page flipping.
module fb_draw_sequencer
    import fb_draw_pkg::*;
#(
    parameter int          FB_W       = 256,
    parameter int          FB_H       = 256,
    parameter int          PIX_W      = 16,
    parameter int          COORD_W    = 10,
    parameter int          ADDR_W     = 23,
    parameter int unsigned BASE_ADDR  = 0,
    parameter int unsigned BUF_STRIDE = 65536,
    parameter int          NUM_BUF    = 2
) (
    input  logic                     iCLK,
    input  logic                     iRST_N,
    fb_draw_sequencer_if.slave       bus,
    input  logic                     iFRAME_START,
    output logic [$clog2(NUM_BUF):0] oFRONT_SEL,
    output logic [ADDR_W-1:0]        oFRONT_BASE,
    output logic                     oBUSY
);
    localparam int SEL_W = $clog2(NUM_BUF) + 1;
    localparam int CW    = COORD_W + 1;
    localparam int SW    = COORD_W + 2;

    state_e            state;
    logic              cmd_ready_q, busy_q;
    logic [SEL_W-1:0]  front_sel, back_sel;
    logic [ADDR_W-1:0] front_base;
    logic [CW-1:0]     x0_q, y0_q, w_q, h_q;
    logic [PIX_W-1:0]  color_q;
    op_e               op;
    logic              accept;

    logic [SW-1:0]     x_sum, y_sum;
    logic [CW-1:0]     x_end, y_end;
    logic              empty, start, last;
    logic [ADDR_W-1:0] back_base, row_base;

    function automatic logic [SEL_W-1:0] sel_inc(input logic [SEL_W-1:0] s);
        return (s == SEL_W'(NUM_BUF - 1)) ? '0 : s + SEL_W'(1);
    endfunction

    assign op     = op_e'(bus.cmd_op);
    assign accept = bus.cmd_valid && cmd_ready_q;

    // Clipping: sums are one bit wider than the operands so they never wrap.
    assign x_sum     = SW'(x0_q) + SW'(w_q);
    assign y_sum     = SW'(y0_q) + SW'(h_q);
    assign x_end     = (x_sum > SW'(FB_W)) ? CW'(FB_W) : CW'(x_sum);
    assign y_end     = (y_sum > SW'(FB_H)) ? CW'(FB_H) : CW'(y_sum);
    assign empty     = (w_q == '0) || (h_q == '0) ||
                       (x0_q >= CW'(FB_W)) || (y0_q >= CW'(FB_H));
    assign back_base = ADDR_W'(page_base(32'(back_sel), BASE_ADDR, BUF_STRIDE));
    assign row_base  = back_base + ADDR_W'(y0_q) * ADDR_W'(FB_W);
    assign start     = (state == S_SETUP) && !empty;

    always_ff @(posedge iCLK) begin
        if (accept) begin
            if (op == OP_CLEAR) begin
                x0_q <= '0;
                y0_q <= '0;
                w_q  <= CW'(FB_W);
                h_q  <= CW'(FB_H);
            end else begin
                x0_q <= CW'(bus.cmd_x0);
                y0_q <= CW'(bus.cmd_y0);
                w_q  <= CW'(bus.cmd_w);
                h_q  <= CW'(bus.cmd_h);
            end
            color_q <= bus.cmd_color;
        end
    end

    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            state       <= S_IDLE;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            front_sel   <= '0;
            back_sel    <= (NUM_BUF > 1) ? SEL_W'(1) : SEL_W'(0);
            front_base  <= ADDR_W'(BASE_ADDR);
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        unique case (op)
                            OP_FILL, OP_CLEAR: begin
                                state       <= S_SETUP;
                                cmd_ready_q <= 1'b0;
                                busy_q      <= 1'b1;
                            end
                            OP_SWAP: begin
                                state       <= S_WAIT_SYNC;
                                cmd_ready_q <= 1'b0;
                                busy_q      <= 1'b1;
                            end
                            OP_NOP: ;
                        endcase
                    end
                end
                S_SETUP: begin
                    if (empty) begin
                        state       <= S_IDLE;
                        cmd_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
                    end else begin
                        state <= S_FILL;
                    end
                end
                S_FILL: begin
                    if (last) begin
                        state       <= S_IDLE;
                        cmd_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
                S_WAIT_SYNC: begin
                    // New back page is always the one after the new front, so it never aliases it.
                    if (iFRAME_START) begin
                        front_sel   <= sel_inc(front_sel);
                        back_sel    <= sel_inc(sel_inc(front_sel));
                        front_base  <= ADDR_W'(page_base(32'(sel_inc(front_sel)), BASE_ADDR, BUF_STRIDE));
                        state       <= S_IDLE;
                        cmd_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state       <= S_IDLE;
                    cmd_ready_q <= 1'b1;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    fb_rect_walker #(
        .FB_W   (FB_W),
        .ADDR_W (ADDR_W),
        .PIX_W  (PIX_W),
        .CW     (CW)
    ) u_walker (
        .clk      (iCLK),
        .rst_n    (iRST_N),
        .start    (start),
        .x0       (x0_q),
        .y0       (y0_q),
        .x_end    (x_end),
        .y_end    (y_end),
        .row_base (row_base),
        .color    (color_q),
        .ready    (bus.wr_ready),
        .valid    (bus.wr_valid),
        .addr     (bus.wr_addr),
        .data     (bus.wr_data),
        .last     (last)
    );

    assign bus.cmd_ready = cmd_ready_q;
    assign oBUSY         = busy_q;
    assign oFRONT_SEL    = front_sel;
    assign oFRONT_BASE   = front_base;
endmodule
